// File: rtl/jzjpcc_mmio.sv
// jzjpcc_mmio: memory-mapped I/O responder on the jzjpcc data-memory bus.
// Decodes a 32-byte window. Provides an output port, a synchronized input port,
// and a free-running compare timer with a sticky pending flag.
module jzjpcc_mmio #(
    parameter logic [31:0] BASE_ADDR         = 32'hFFFFFFE0,
    parameter int unsigned INPUT_SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    input  logic [3:0]  byteWriteMask,
    input  logic        writeEnable,
    input  logic        readEnable,
    output logic [31:0] readData,
    output logic        hit,
    input  logic [31:0] portAIn,
    output logic [31:0] portAOut,
    output logic        timerIrq
);

    localparam logic [2:0] OFF_PORTA_OUT     = 3'd0;
    localparam logic [2:0] OFF_PORTA_IN      = 3'd1;
    localparam logic [2:0] OFF_TIMER_COUNT   = 3'd2;
    localparam logic [2:0] OFF_TIMER_COMPARE = 3'd3;
    localparam logic [2:0] OFF_TIMER_CTRL    = 3'd4;

    // TIMER_CTRL bit positions
    localparam int CTRL_EN      = 0;
    localparam int CTRL_RELOAD  = 1;
    localparam int CTRL_PENDING = 2;

    logic [31:0] porta_q, porta_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] read_data_q, read_data_d;
    logic        hit_q, hit_d;
    logic [31:0] sync_q [INPUT_SYNC_STAGES];

    logic        in_window;
    logic [2:0]  offset;
    logic        wr_hit;
    logic        timer_match;
    logic        unused_addr_lsbs;

    assign in_window        = (address[31:5] == BASE_ADDR[31:5]);
    assign offset           = address[4:2];
    assign wr_hit           = writeEnable && in_window;
    assign unused_addr_lsbs = ^address[1:0];

    // Replace only the byte lanes enabled in the mask.
    function automatic logic [31:0] apply_mask(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  mask);
        logic [31:0] result;
        for (int b = 0; b < 4; b++) begin
            result[8*b +: 8] = mask[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return result;
    endfunction

    // Synchronizer chain for the asynchronous input port.
    always_ff @(posedge clock) begin
        // NOTE: the sync stages are an array but still get reset, so a read of
        // PORTA_IN right after reset returns 0 rather than stale data.
        if (reset) begin
            for (int i = 0; i < int'(INPUT_SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= portAIn;
            for (int i = 1; i < int'(INPUT_SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Next-state for the register file: timer advance, then software writes.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        porta_d     = porta_q;
        count_d     = count_q;
        compare_d   = compare_q;
        ctrl_d      = ctrl_q;
        timer_match = ctrl_q[CTRL_EN] && (count_q == compare_q);

        if (ctrl_q[CTRL_EN]) begin
            count_d = (timer_match && ctrl_q[CTRL_RELOAD]) ? '0 : count_q + 32'd1;
        end

        if (wr_hit) begin
            case (offset)
                OFF_PORTA_OUT:     porta_d   = apply_mask(porta_q, writeData, byteWriteMask);
                // A software write overrides the timer: unmasked lanes keep the
                // pre-edge count with no increment.
                OFF_TIMER_COUNT:   count_d   = apply_mask(count_q, writeData, byteWriteMask);
                OFF_TIMER_COMPARE: compare_d = apply_mask(compare_q, writeData, byteWriteMask);
                OFF_TIMER_CTRL: begin
                    if (byteWriteMask[0]) begin
                        ctrl_d[CTRL_RELOAD:CTRL_EN] = writeData[CTRL_RELOAD:CTRL_EN];
                        if (writeData[CTRL_PENDING]) begin
                            ctrl_d[CTRL_PENDING] = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end

        // A match beats a simultaneous write-1-to-clear.
        if (timer_match) begin
            ctrl_d[CTRL_PENDING] = 1'b1;
        end
    end

    // Read mux over pre-edge register values, gated by readEnable and decode.
    always_comb begin
        read_data_d = '0;
        hit_d       = readEnable && in_window;
        if (hit_d) begin
            case (offset)
                OFF_PORTA_OUT:     read_data_d = porta_q;
                OFF_PORTA_IN:      read_data_d = sync_q[INPUT_SYNC_STAGES-1];
                OFF_TIMER_COUNT:   read_data_d = count_q;
                OFF_TIMER_COMPARE: read_data_d = compare_q;
                OFF_TIMER_CTRL:    read_data_d = {29'd0, ctrl_q};
                default:           read_data_d = '0;
            endcase
        end
    end

    // Register file and registered read port.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            porta_q     <= '0;
            count_q     <= '0;
            compare_q   <= '0;
            ctrl_q      <= '0;
            read_data_q <= '0;
            hit_q       <= 1'b0;
        end else begin
            porta_q     <= porta_d;
            count_q     <= count_d;
            compare_q   <= compare_d;
            ctrl_q      <= ctrl_d;
            read_data_q <= read_data_d;
            hit_q       <= hit_d;
        end
    end

    assign readData = read_data_q;
    assign hit      = hit_q;
    assign portAOut = porta_q;
    assign timerIrq = ctrl_q[CTRL_PENDING];

endmodule

// File: tb/tb_jzjpcc_mmio.sv
// Scoreboard bench for jzjpcc_mmio: the driver pushes the expected readData/hit
// for every bus cycle; a monitor pops and compares one entry after each edge.
module tb_jzjpcc_mmio;

    localparam logic [31:0] BASE = 32'hFFFFFFE0;
    localparam logic [31:0] A_PORTA_OUT = BASE + 32'h00;
    localparam logic [31:0] A_PORTA_IN  = BASE + 32'h04;
    localparam logic [31:0] A_COUNT     = BASE + 32'h08;
    localparam logic [31:0] A_COMPARE   = BASE + 32'h0C;
    localparam logic [31:0] A_CTRL      = BASE + 32'h10;

    typedef struct packed {
        logic [31:0] data;
        logic        hit;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] address = '0;
    logic [31:0] writeData = '0;
    logic [3:0]  byteWriteMask = '0;
    logic        writeEnable = 1'b0;
    logic        readEnable = 1'b0;
    logic [31:0] readData;
    logic        hit;
    logic [31:0] portAIn = '0;
    logic [31:0] portAOut;
    logic        timerIrq;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    jzjpcc_mmio #(.BASE_ADDR(BASE), .INPUT_SYNC_STAGES(2)) dut (
        .clock         (clock),
        .reset         (reset),
        .address       (address),
        .writeData     (writeData),
        .byteWriteMask (byteWriteMask),
        .writeEnable   (writeEnable),
        .readEnable    (readEnable),
        .readData      (readData),
        .hit           (hit),
        .portAIn       (portAIn),
        .portAOut      (portAOut),
        .timerIrq      (timerIrq)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    // One bus cycle: drive, record the expectation, pass one rising edge.
    task automatic access(input logic re, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] mask,
                          input logic [31:0] exp_d, input logic exp_hit);
        readEnable    = re;
        writeEnable   = we;
        address       = addr;
        writeData     = wd;
        byteWriteMask = mask;
        sb_q.push_back('{data: exp_d, hit: exp_hit});
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp_d);
        access(1'b1, 1'b0, addr, 32'h0, 4'h0, exp_d, 1'b1);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] mask);
        access(1'b0, 1'b1, addr, wd, mask, 32'h0, 1'b0);
    endtask

    task automatic idle();
        access(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
    endtask

    // Monitor: compare the registered read port shortly after each edge.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("readData", readData, e.data);
            check("hit", {31'd0, hit}, {31'd0, e.hit});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] seq_reload [8];
        logic [31:0] seq_wrap [7];
        seq_reload = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd0, 32'd1};
        seq_wrap   = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4};

        // Reset, then every offset reads 0 with hit.
        @(negedge clock);
        idle();
        idle();
        reset = 1'b0;
        check("rst_portAOut", portAOut, 32'h0);
        check("rst_timerIrq", {31'd0, timerIrq}, 32'h0);
        for (int k = 0; k < 8; k++) begin
            rd(BASE + 32'(4 * k), 32'h0);
        end
        access(1'b1, 1'b0, BASE - 32'd4, 32'h0, 4'h0, 32'h0, 1'b0);

        // Reserved offset ignores writes.
        wr(BASE + 32'h14, 32'hFFFFFFFF, 4'hF);
        rd(BASE + 32'h14, 32'h0);

        // Byte-masked writes to PORTA_OUT; same-cycle read returns old value.
        wr(A_PORTA_OUT, 32'hA5A5A5A5, 4'b1111);
        access(1'b1, 1'b1, A_PORTA_OUT, 32'h0000FF00, 4'b0010, 32'hA5A5A5A5, 1'b1);
        check("portAOut_masked", portAOut, 32'hA5A5FFA5);
        rd(A_PORTA_OUT, 32'hA5A5FFA5);
        // Out-of-window write with the same low bits is dropped.
        wr(BASE - 32'd32, 32'h0, 4'hF);
        rd(A_PORTA_OUT, 32'hA5A5FFA5);
        // PORTA_IN is read-only.
        wr(A_PORTA_IN, 32'hFFFFFFFF, 4'hF);

        // Input synchronizer: new value visible three cycles after the change.
        portAIn = 32'h12345678;
        rd(A_PORTA_IN, 32'h0);
        rd(A_PORTA_IN, 32'h0);
        rd(A_PORTA_IN, 32'h12345678);
        rd(A_PORTA_IN, 32'h12345678);

        // Auto-reload timer with compare = 5.
        wr(A_COMPARE, 32'd5, 4'hF);
        wr(A_CTRL, 32'h3, 4'h1);
        for (int i = 0; i < 8; i++) begin
            rd(A_COUNT, seq_reload[i]);
            if (i == 4) check("irq_before_match", {31'd0, timerIrq}, 32'h0);
            if (i == 5) check("irq_after_match", {31'd0, timerIrq}, 32'h1);
        end
        // Count is 2 here: clear with no match.
        wr(A_CTRL, 32'h7, 4'h1);
        check("irq_cleared", {31'd0, timerIrq}, 32'h0);
        idle();  // 3 -> 4
        idle();  // 4 -> 5
        wr(A_CTRL, 32'h7, 4'h1);  // clear on the match cycle: set wins
        check("irq_set_wins", {31'd0, timerIrq}, 32'h1);
        rd(A_CTRL, 32'h7);

        // Wrap test without reload, compare = 3.
        wr(A_CTRL, 32'h4, 4'h1);  // disable, clear pending
        wr(A_COUNT, 32'hFFFFFFFE, 4'hF);
        wr(A_COMPARE, 32'd3, 4'hF);
        wr(A_CTRL, 32'h1, 4'h1);
        for (int i = 0; i < 7; i++) begin
            rd(A_COUNT, seq_wrap[i]);
            if (i == 4) check("wrap_irq_before", {31'd0, timerIrq}, 32'h0);
            if (i == 5) check("wrap_irq_after", {31'd0, timerIrq}, 32'h1);
        end
        rd(A_COUNT, 32'd5);

        // Masked software write to a running count.
        wr(A_CTRL, 32'h4, 4'h1);
        wr(A_COUNT, 32'h0000010F, 4'hF);
        wr(A_CTRL, 32'h1, 4'h1);
        idle();  // 0x10F -> 0x110
        wr(A_COUNT, 32'h000000AA, 4'b0001);
        rd(A_COUNT, 32'h000001AA);

        // Reset with a read in flight.
        reset = 1'b1;
        access(1'b1, 1'b0, A_COUNT, 32'h0, 4'h0, 32'h0, 1'b0);
        reset = 1'b0;
        check("reset_portAOut", portAOut, 32'h0);
        check("reset_timerIrq", {31'd0, timerIrq}, 32'h0);
        rd(A_COUNT, 32'h0);
        rd(A_CTRL, 32'h0);
        rd(A_COMPARE, 32'h0);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jzjpcc_mmio.md
# jzjpcc_mmio

Memory-mapped I/O responder for the jzjpcc core's data-memory port. It decodes a 32-byte window of the core's load/store address space and sits beside the inferred SRAM on the same bus. It services core-initiated reads and writes with the same one-cycle registered read latency and byte write masking as the SRAM. It provides a 32-bit output port, a synchronized 32-bit input port, and a free-running compare timer with a sticky interrupt flag.

## Interface
- BASE_ADDR, default 32'hFFFFFFE0: byte address of register 0; must be 32-byte aligned.
- INPUT_SYNC_STAGES, default 2: flop stages on portAIn, 2..3.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- address  in  32  core byte address; bits [1:0] are ignored.
- writeData  in  32  store data, already lane-aligned.
- byteWriteMask  in  4  bit n enables byte lane n (bits [8n+7:8n]).
- writeEnable  in  1  store strobe.
- readEnable  in  1  load strobe.
- readData  out  32  registered load data.
- hit  out  1  registered: the previous cycle's access fell in the window.
- portAIn  in  32  asynchronous external inputs.
- portAOut  out  32  output port register.
- timerIrq  out  1  equals the TIMER_CTRL pending bit.

## Operation
- Decode: in window iff address[31:5] == BASE_ADDR[31:5]. Word offset = address[4:2].
- Register map:
  - 0x00 PORTA_OUT, RW.
  - 0x04 PORTA_IN, RO; returns portAIn after INPUT_SYNC_STAGES flops.
  - 0x08 TIMER_COUNT, RW.
  - 0x0C TIMER_COMPARE, RW.
  - 0x10 TIMER_CTRL: bit0 enable (RW); bit1 autoReload (RW); bit2 pending (write 1 to clear); other bits read 0.
  - 0x14–0x1C: reserved; read 0, writes ignored.
- Writes apply only to byte lanes with the mask bit set. For RO and reserved offsets, and for out-of-window addresses, writes are dropped.
- Timer, when enable is 1:
  - Each cycle, count ← count+1, wrapping 32'hFFFFFFFF → 0.
  - If count == compare, pending ← 1.
  - If count == compare and autoReload is 1, count ← 0 instead of count+1.
- When enable is 0, count holds and no match is evaluated.
- Priority:
  - A software write to TIMER_COUNT in the same cycle as a timer update: the masked lanes take writeData; the unmasked lanes keep the pre-edge count, with no increment.
  - Pending set and a write-1-to-clear in the same cycle: set wins.
- Read-before-write: a read and a write to the same register in the same cycle return the old value.
- readEnable and writeEnable may both be high; both are serviced.

## Timing
- Read latency is 1 cycle. If readEnable is high and the address is in window at edge N, readData after edge N holds the register value from before edge N, and hit = 1.
- If readEnable is low or the address misses, readData = 0 and hit = 0 after the edge. The bus mux ORs readData onto the SRAM data.
- Writes take effect at the same edge; the register shows the new value on a read issued the next cycle.
- portAIn → PORTA_IN read value: INPUT_SYNC_STAGES cycles, plus 1 cycle of read latency.
- timerIrq asserts the cycle after the matching edge. This is the same edge that writes pending.
- Reset (any cycle, including mid-access) clears:
  - readData, hit, portAOut, count, compare and ctrl to 0, so timerIrq = 0;
  - all sync flops to 0.
  - A read in flight during reset returns 0.
- No back-pressure: the block accepts one access per cycle, every cycle.

## Test plan
- Reset, then read every offset: all return 0, hit = 1, timerIrq = 0. A read at BASE_ADDR-4 returns readData = 0 and hit = 0.
- Write 32'hA5A5A5A5 to PORTA_OUT with mask 4'b1111, then 32'h0000FF00 with mask 4'b0010: portAOut = 32'hA5A5FFA5, and a read returns the same value.
- Drive portAIn = 32'h12345678 and read PORTA_IN each cycle: the new value first appears on readData exactly INPUT_SYNC_STAGES+1 cycles after the input changes.
- Set compare = 5, ctrl = 3'b011 (enable, autoReload): count sequence 0,1,2,3,4,5,0,1,…; timerIrq rises after the 5 → 0 edge. Write 3'b111 to ctrl: pending clears next cycle. Repeat the clear on a match cycle: pending stays 1.
- Set count = 32'hFFFFFFFE, compare = 3, enable only: count goes FFFFFFFE, FFFFFFFF, 0, 1, 2, 3, 4; pending sets at 3, and count continues to 4 with no reload.
- Enable the timer, write TIMER_COUNT with mask 4'b0001 and data 32'h000000AA while count = 32'h00000110: the next count is 32'h000001AA. Then assert reset mid-count: all outputs are 0 on the following cycle.
